// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap chain and its coefficient loader.
// FIR_COEF_SYMMETRIC_EN selects half-length (linear-phase) coefficient frames.
package fir_pkg;

    localparam int DEFAULT_DATA_WIDTH = 24;

    typedef enum logic {
        ST_LOAD    = 1'b0,
        ST_PENDING = 1'b1
    } load_state_t;

    // Number of beats in one coefficient frame.
    function automatic int coef_frame_len(input int num_taps);
`ifdef FIR_COEF_SYMMETRIC_EN
        return (num_taps + 1) / 2;
`else
        return num_taps;
`endif
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient register pair with single-cycle bulk swap.
// FIR_COEF_SYMMETRIC_EN mirrors each write onto tap NUM_TAPS-1-idx.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_TAPS   = 16,
    parameter int IDX_WIDTH  = $clog2(NUM_TAPS + 1)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_wr_en,
    input  logic [IDX_WIDTH-1:0]           i_wr_idx,
    input  logic [DATA_WIDTH-1:0]          iv_wr_data,
    input  logic                           i_swap,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_active
);

    logic [DATA_WIDTH-1:0] shadow [NUM_TAPS];

    // NOTE: the shadow bank is storage only and is always fully rewritten
    // before use, so it carries no reset; only the visible active bank does.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
`ifdef FIR_COEF_SYMMETRIC_EN
            if (i_wr_en && (int'(i_wr_idx) == k || int'(i_wr_idx) == NUM_TAPS - 1 - k))
`else
            if (i_wr_en && int'(i_wr_idx) == k)
`endif
                shadow[k] <= iv_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ov_active <= '0;
        end else if (i_swap) begin
            for (int k = 0; k < NUM_TAPS; k++)
                ov_active[k*DATA_WIDTH +: DATA_WIDTH] <= shadow[k];
        end
    end

endmodule

// File: rtl/fir_coef_loader.sv
// Framed coefficient loader: collects a frame in a shadow bank, then swaps it
// atomically into the active tap weights. Build option: FIR_COEF_SYMMETRIC_EN.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_TAPS   = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_coef_valid,
    input  logic [DATA_WIDTH-1:0]            iv_coef,
    input  logic                             i_coef_last,
    output logic                             o_coef_ready,
    input  logic                             i_swap_en,
    output logic [NUM_TAPS*DATA_WIDTH-1:0]   ov_weights,
    output logic                             o_bank_valid,
    output logic                             o_swap,
    output logic                             o_frame_err,
    output logic [$clog2(NUM_TAPS+1)-1:0]    ov_load_count
);

    localparam int CW        = $clog2(NUM_TAPS + 1);
    localparam int FRAME_LEN = coef_frame_len(NUM_TAPS);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    load_state_t   state;
    logic [CW-1:0] idx;
    logic          accept;
    logic          do_swap;

    assign accept        = i_coef_valid && o_coef_ready;
    assign do_swap       = (state == ST_PENDING) && i_swap_en;
    assign ov_load_count = idx;

    // NOTE: all state here is registered with non-blocking assignments so every
    // output reflects the same edge and ready never depends on valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_LOAD;
            idx          <= '0;
            o_coef_ready <= 1'b0;
            o_bank_valid <= 1'b0;
            o_swap       <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_swap      <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                ST_LOAD: begin
                    o_coef_ready <= 1'b1;
                    if (accept) begin
                        if (i_coef_last && idx == LAST_IDX) begin
                            state        <= ST_PENDING;
                            o_coef_ready <= 1'b0;
                            idx          <= idx + 1'b1;
                        end else if (i_coef_last || idx == LAST_IDX) begin
                            // Short frame or missing last: drop it and restart.
                            o_frame_err <= 1'b1;
                            idx         <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_PENDING: begin
                    if (i_swap_en) begin
                        state        <= ST_LOAD;
                        o_coef_ready <= 1'b1;
                        o_swap       <= 1'b1;
                        o_bank_valid <= 1'b1;
                        idx          <= '0;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    fir_coef_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_TAPS   (NUM_TAPS),
        .IDX_WIDTH  (CW)
    ) u_bank (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_en    (accept),
        .i_wr_idx   (idx),
        .iv_wr_data (iv_coef),
        .i_swap     (do_swap),
        .ov_active  (ov_weights)
    );

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench: 4-tap loader for framing/handshake, 5-tap loader for the
// FIR_COEF_SYMMETRIC_EN fan-out (expects a frame error in the default build).
module tb_fir_coef_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-tap, 8-bit instance
    logic        rst, valid, clast, rdy, swap_en, bv, swp, err;
    logic [7:0]  data;
    logic [31:0] w;
    logic [2:0]  cnt;

    fir_coef_loader #(.DATA_WIDTH(8), .NUM_TAPS(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_coef_valid(valid), .iv_coef(data),
        .i_coef_last(clast), .o_coef_ready(rdy), .i_swap_en(swap_en),
        .ov_weights(w), .o_bank_valid(bv), .o_swap(swp), .o_frame_err(err),
        .ov_load_count(cnt)
    );

    // 5-tap, 8-bit instance
    logic        s_rst, s_valid, s_last, s_rdy, s_swap_en, s_bv, s_swp, s_err;
    logic [7:0]  s_data;
    logic [39:0] s_w;
    logic [2:0]  s_cnt;

    fir_coef_loader #(.DATA_WIDTH(8), .NUM_TAPS(5)) dut5 (
        .i_clk(clk), .i_rst(s_rst), .i_coef_valid(s_valid), .iv_coef(s_data),
        .i_coef_last(s_last), .o_coef_ready(s_rdy), .i_swap_en(s_swap_en),
        .ov_weights(s_w), .o_bank_valid(s_bv), .o_swap(s_swp), .o_frame_err(s_err),
        .ov_load_count(s_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds one beat until the 4-tap loader accepts it; optional random valid gaps.
    task automatic send_beat(input logic [7:0] d, input logic last, input bit gaps);
        int  guard = 0;
        bit  took  = 0;
        data  = d;
        clast = last;
        while (!took && guard < 64) begin
            valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            took  = valid && rdy;
            step();
            guard++;
        end
        valid = 1'b0;
        clast = 1'b0;
        if (!took) check("beat_timeout", 64'd0, 64'd1);
    endtask

    typedef struct {
        int          n;
        logic [7:0]  b [4];
        int          last_at;
        bit          bad;
        logic [31:0] exp_w;
    } frame_vec_t;

    frame_vec_t  vec [5];
    logic [31:0] prev_w;
    logic [31:0] model;
    logic [7:0]  beat;

    initial begin
        vec[0] = '{n: 4, b: '{8'h10, 8'h20, 8'h30, 8'h40}, last_at: 3,  bad: 0, exp_w: 32'h40302010};
        vec[1] = '{n: 2, b: '{8'haa, 8'hbb, 8'h00, 8'h00}, last_at: 1,  bad: 1, exp_w: 32'h40302010};
        vec[2] = '{n: 4, b: '{8'hc1, 8'hc2, 8'hc3, 8'hc4}, last_at: -1, bad: 1, exp_w: 32'h40302010};
        vec[3] = '{n: 4, b: '{8'h01, 8'h02, 8'h03, 8'h04}, last_at: 3,  bad: 0, exp_w: 32'h04030201};
        vec[4] = '{n: 4, b: '{8'h80, 8'h7f, 8'hff, 8'h00}, last_at: 3,  bad: 0, exp_w: 32'h00ff7f80};

        rst = 1; valid = 0; clast = 0; data = '0; swap_en = 0;
        s_rst = 1; s_valid = 0; s_last = 0; s_data = '0; s_swap_en = 0;
        step(); step();
        check("rst_weights", 64'(w), 64'd0);
        check("rst_bank_valid", 64'(bv), 64'd0);
        check("rst_ready", 64'(rdy), 64'd0);
        check("rst_count", 64'(cnt), 64'd0);
        check("rst_swap", 64'(swp), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 0; s_rst = 0;
        step();
        check("ready_after_rst", 64'(rdy), 64'd1);

        // Swap enable in LOAD must do nothing
        swap_en = 1;
        step();
        check("swap_in_load_ignored", 64'(swp), 64'd0);
        check("bank_still_invalid", 64'(bv), 64'd0);
        swap_en = 0;

        // Table-driven frames
        prev_w = 32'd0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < vec[i].n; j++)
                send_beat(vec[i].b[j], logic'(j == vec[i].last_at), 1'b0);
            if (vec[i].bad) begin
                check($sformatf("v%0d_err_pulse", i), 64'(err), 64'd1);
                check($sformatf("v%0d_count_cleared", i), 64'(cnt), 64'd0);
                step();
                check($sformatf("v%0d_err_single", i), 64'(err), 64'd0);
                check($sformatf("v%0d_weights_kept", i), 64'(w), 64'(vec[i].exp_w));
            end else begin
                check($sformatf("v%0d_pending_ready", i), 64'(rdy), 64'd0);
                check($sformatf("v%0d_pending_count", i), 64'(cnt), 64'd4);
                check($sformatf("v%0d_weights_unchanged", i), 64'(w), 64'(prev_w));
                swap_en = 1;
                step();
                swap_en = 0;
                check($sformatf("v%0d_swap_pulse", i), 64'(swp), 64'd1);
                check($sformatf("v%0d_weights", i), 64'(w), 64'(vec[i].exp_w));
                check($sformatf("v%0d_bank_valid", i), 64'(bv), 64'd1);
                check($sformatf("v%0d_ready_back", i), 64'(rdy), 64'd1);
                check($sformatf("v%0d_count_zero", i), 64'(cnt), 64'd0);
                check($sformatf("v%0d_no_err", i), 64'(err), 64'd0);
                step();
                check($sformatf("v%0d_swap_single", i), 64'(swp), 64'd0);
                prev_w = vec[i].exp_w;
            end
        end

        // Swap held off for 5 cycles
        for (int j = 0; j < 4; j++) send_beat(8'(8'ha1 + j), logic'(j == 3), 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("holdoff_ready", 64'(rdy), 64'd0);
            check("holdoff_weights", 64'(w), 64'h00ff7f80);
            step();
        end
        swap_en = 1;
        step();
        swap_en = 0;
        check("holdoff_swap", 64'(swp), 64'd1);
        check("holdoff_new_weights", 64'(w), 64'ha4a3a2a1);

        // Reset mid-frame, then a clean frame
        send_beat(8'h55, 1'b0, 1'b0);
        send_beat(8'h66, 1'b0, 1'b0);
        rst = 1;
        step();
        check("midrst_weights", 64'(w), 64'd0);
        check("midrst_bank_valid", 64'(bv), 64'd0);
        check("midrst_ready", 64'(rdy), 64'd0);
        check("midrst_count", 64'(cnt), 64'd0);
        rst = 0;
        step();
        for (int j = 0; j < 4; j++) send_beat(8'(j + 1), logic'(j == 3), 1'b0);
        check("midrst_no_err", 64'(err), 64'd0);
        check("midrst_pending_count", 64'(cnt), 64'd4);
        swap_en = 1;
        step();
        swap_en = 0;
        check("midrst_swap", 64'(swp), 64'd1);
        check("midrst_new_weights", 64'(w), 64'h04030201);

        // 5-tap instance: symmetric fan-out or a short-frame error
        check("sym_ready", 64'(s_rdy), 64'd1);
        for (int j = 0; j < 3; j++) begin
            s_valid = 1;
            s_data  = 8'(8'h11 * (j + 1));
            s_last  = logic'(j == 2);
            step();
        end
        s_valid = 0; s_last = 0;
`ifdef FIR_COEF_SYMMETRIC_EN
        check("sym_pending_count", 64'(s_cnt), 64'd3);
        check("sym_pending_ready", 64'(s_rdy), 64'd0);
        s_swap_en = 1;
        step();
        s_swap_en = 0;
        check("sym_swap", 64'(s_swp), 64'd1);
        check("sym_weights", 64'(s_w), 64'h1122332211);
`else
        check("nonsym_short_err", 64'(s_err), 64'd1);
        check("nonsym_count", 64'(s_cnt), 64'd0);
        step();
        check("nonsym_weights_kept", 64'(s_w), 64'd0);
        check("nonsym_bank_invalid", 64'(s_bv), 64'd0);
`endif

        // Backpressure: random valid gaps, swap one cycle into PENDING
        for (int f = 0; f < 3; f++) begin
            model = '0;
            for (int j = 0; j < 4; j++) begin
                beat = 8'($urandom);
                model[j*8 +: 8] = beat;
                send_beat(beat, logic'(j == 3), 1'b1);
                if (j < 3) check("bp_count", 64'(cnt), 64'(j + 1));
            end
            check("bp_pending_count", 64'(cnt), 64'd4);
            step();
            check("bp_still_pending", 64'(rdy), 64'd0);
            swap_en = 1;
            step();
            swap_en = 0;
            check("bp_swap", 64'(swp), 64'd1);
            check("bp_weights", 64'(w), 64'(model));
            check("bp_no_err", 64'(err), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_coef_loader.md
# fir_coef_loader

Coefficient writer for the transposed FIR tap chain. It accepts a framed stream of Q1.(DATA_WIDTH-1) weights over a valid/ready handshake and collects them in a shadow bank. It then swaps the whole set into the active bank that drives every tap's weight input in a single cycle, so the filter never runs on a partially loaded set. Sits between the host/config path and the tap array.

## Interface
Parameters:
- DATA_WIDTH, 24, coefficient width, signed Q1.(DATA_WIDTH-1)
- NUM_TAPS, 16, number of taps driven (≥2)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_coef_valid  in  1  coefficient beat valid
- iv_coef  in  DATA_WIDTH  coefficient value
- i_coef_last  in  1  marks final beat of a frame
- o_coef_ready  out  1  loader can accept a beat
- i_swap_en  in  1  swap permitted this cycle (filter between samples)
- ov_weights  out  NUM_TAPS*DATA_WIDTH  active bank; tap k at [k*DATA_WIDTH +: DATA_WIDTH]
- o_bank_valid  out  1  active bank holds a committed set
- o_swap  out  1  one-cycle pulse: active bank updated
- o_frame_err  out  1  one-cycle pulse: malformed frame discarded
- ov_load_count  out  $clog2(NUM_TAPS+1)  beats held in shadow bank

## Operation
- Frame length L = NUM_TAPS (see Configuration for the symmetric case). Beat index 0 goes to tap 0.
- A beat is accepted when i_coef_valid && o_coef_ready. The accepted value is written to shadow[idx], and idx increments.
- States: LOAD, PENDING.
- LOAD: o_coef_ready=1.
  - An accepted beat at idx==L-1 with i_coef_last=1 moves the block to PENDING.
  - An accepted beat with i_coef_last=1 at idx<L-1 is an error.
  - An accepted beat at idx==L-1 with i_coef_last=0 is an error.
  - On error: o_frame_err pulses, idx←0, the shadow contents are don't-care, the state stays LOAD, and the active bank is untouched.
- PENDING: o_coef_ready=0; the block waits for i_swap_en.
  - At the edge where PENDING && i_swap_en: active←shadow, o_swap=1 for the following cycle, o_bank_valid←1, idx←0, and the state returns to LOAD.
- A swap of the complete set is atomic; no tap ever sees a mix of old and new weights.
- The shadow bank is separate from the active bank. Loading never alters ov_weights.
- Width rule: values pass through unmodified. No saturation or truncation is applied.

## Timing
- Reset (any cycle, including mid-frame or in PENDING):
  - ov_weights=0, o_bank_valid=0, o_swap=0, o_frame_err=0, ov_load_count=0, o_coef_ready=0.
  - The state is LOAD; o_coef_ready rises the first cycle after i_rst deasserts.
  - A partial frame is discarded.
- o_coef_ready is registered and depends only on state, never combinationally on i_coef_valid.
- The last beat is accepted at edge t, so the block is PENDING and o_coef_ready=0 in cycle t+1.
- If i_swap_en=1 in cycle t+1:
  - ov_weights shows the new set and o_swap=1 in cycle t+2.
  - o_coef_ready=1 in cycle t+2.
- A back-to-back frame can be accepted starting in cycle t+2. The minimum frame period is L+1 cycles.
- ov_load_count reads L while PENDING and 0 after a swap or an error.
- o_frame_err is asserted in the cycle after the offending beat.
- i_swap_en while in LOAD is ignored.

## Configuration
- FIR_COEF_SYMMETRIC_EN defined:
  - L = ceil(NUM_TAPS/2).
  - Beat j is written to shadow taps j and NUM_TAPS-1-j. For odd NUM_TAPS the centre tap is written once.
  - This suits linear-phase filters.
- Not defined: L = NUM_TAPS and each beat writes exactly one tap.
- The handshake, states and timing are identical in both builds; only L and the write fan-out change.

## Structure
- Shared package fir_pkg holds:
  - the default DATA_WIDTH
  - the state encoding constants (ST_LOAD, ST_PENDING)
  - a function computing L from NUM_TAPS under the macro
- fir_pkg is shared with the tap chain's top level.
- Sub-module fir_coef_bank: NUM_TAPS×DATA_WIDTH register array with a write port and a bulk copy-on-swap; instantiated once for shadow+active.
- The FSM, index counter and error detection live in fir_coef_loader.

## Test plan
Tests 1–4 use NUM_TAPS=4 and DATA_WIDTH=8; test 5 uses NUM_TAPS=5.
1. Basic load: after reset, send 0x10,0x20,0x30,0x40 with last on the 4th beat, i_swap_en=1 → ov_weights=0x40302010 one cycle after PENDING, o_swap single pulse, o_bank_valid=1.
2. Swap held off: complete a frame with i_swap_en=0 for 5 cycles → o_coef_ready=0 and ov_weights unchanged throughout; raise i_swap_en → swap on the next edge.
3. Framing errors (non-symmetric build):
   - last on beat 2 → o_frame_err pulse, ov_weights keeps its previous set.
   - 4 beats without last → o_frame_err pulse, ov_weights keeps its previous set.
4. Reset mid-operation: reset after 2 of 4 beats, then after reset send a full frame 0x01..0x04 → ov_weights=0x04030201 with no error.
5. Symmetric build (FIR_COEF_SYMMETRIC_EN, NUM_TAPS=5): send 0x11,0x22,0x33 with last → taps 0..4 = 0x11,0x22,0x33,0x22,0x11.
6. Backpressure: random i_coef_valid gaps and swap 1 cycle after PENDING → each beat is accepted exactly once, and the reference model matches ov_weights after every o_swap.
